// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encodings and timer sizing for the PLL reset sequencer
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Timer must hold the largest per-state cycle budget; one spare bit keeps it clear of wrap.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for a single asynchronous bit
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the chain; reset clears every stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset / lock supervisor releasing system reset after stable lock
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SYS_RST_HOLD_CYCLES = 64,
  parameter int SYNC_STAGES         = 2,
  parameter int CNT_W               = 8
) (
  input  logic               i_clkin,
  input  logic               i_reset,
  input  logic               i_pll_lock,
  output logic               o_pll_reset,
  output logic               o_sys_rst,
  output logic               o_ready,
  output logic [CNT_W-1:0]   o_retry_count,
  output logic [CNT_W-1:0]   o_lock_loss_count,
  output logic [STATE_W-1:0] o_state_dbg
);

  localparam int TIMER_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES, SYS_RST_HOLD_CYCLES);

  localparam logic [TIMER_W-1:0] PLL_END     = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_END = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_END  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_END    = TIMER_W'(SYS_RST_HOLD_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [TIMER_W-1:0] r_timer;
  logic [CNT_W-1:0]   r_retry_count;
  logic [CNT_W-1:0]   r_lock_loss_count;
  logic               r_pll_reset;
  logic               r_sys_rst;
  logic               r_ready;
  logic               w_lock_s;
  logic               w_retry_inc;
  logic               w_loss_inc;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (i_clkin),
    .i_reset (i_reset),
    .i_d     (i_pll_lock),
    .o_q     (w_lock_s)
  );

  // Next-state and counter-event decode; a lock drop is checked before any timer expiry.
  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_timer == PLL_END) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next = S_STABLE;
        end else if (r_timer == TIMEOUT_END) begin
          w_next      = S_PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!w_lock_s) w_next = S_WAIT_LOCK;
        else if (r_timer == STABLE_END) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (!w_lock_s) w_next = S_PLL_RST;
        else if (r_timer == HOLD_END) w_next = S_RUN;
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_next     = S_PLL_RST;
          w_loss_inc = 1'b1;
        end
      end
      default: w_next = S_PLL_RST;
    endcase
  end

  // State register plus outputs decoded from the next state so they move with the state.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_state     <= S_PLL_RST;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pll_reset <= (w_next == S_PLL_RST);
      r_sys_rst   <= (w_next != S_RUN);
      r_ready     <= (w_next == S_RUN);
    end
  end

  // Shared timer counts cycles spent in the current state; idle in RUN, cleared on any move.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if ((w_next != r_state) || (r_state == S_RUN)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  // Saturating event counters for lock timeouts and in-service lock losses.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_retry_count     <= '0;
      r_lock_loss_count <= '0;
    end else begin
      if (w_retry_inc && (r_retry_count != {CNT_W{1'b1}})) begin
        r_retry_count <= r_retry_count + CNT_W'(1);
      end
      if (w_loss_inc && (r_lock_loss_count != {CNT_W{1'b1}})) begin
        r_lock_loss_count <= r_lock_loss_count + CNT_W'(1);
      end
    end
  end

  assign o_pll_reset       = r_pll_reset;
  assign o_sys_rst         = r_sys_rst;
  assign o_ready           = r_ready;
  assign o_retry_count     = r_retry_count;
  assign o_lock_loss_count = r_lock_loss_count;
  assign o_state_dbg       = r_state;

endmodule
